// File: rtl/schoolbook_divider_if.sv
// Handshake and operand/result bundle for the restoring divider.
// The master issues start/a/b; the slave returns busy/done and the results.
interface schoolbook_divider_if #(
    parameter int unsigned N = 521
);
    logic             start;
    logic [2*N-1:0]   a;
    logic [N-1:0]     b;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   q;
    logic [N-1:0]     r;
    logic             div_by_zero;

    modport master (
        output start, a, b,
        input  busy, done, q, r, div_by_zero
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, div_by_zero
    );
endinterface

// File: rtl/schoolbook_divider.sv
// Restoring shift-and-subtract divider: 2N-bit dividend by N-bit divisor,
// one quotient bit per clock, start/busy/done handshake.
module schoolbook_divider #(
    parameter int unsigned N  = 521,
    parameter int unsigned CW = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    schoolbook_divider_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CW-1:0] LAST = CW'(2*N-1);

    state_t          state_q, state_d;
    logic [2*N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]    dsr_q, dsr_d;
    logic [N-1:0]    rem_q, rem_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dbz_q, dbz_d;

    logic [N:0]      trial;
    logic [N-1:0]    diff;
    logic            ge;

    // Quotient bits shift into the dividend register's vacated LSB, so after
    // 2N steps that register holds the quotient.
    always_comb begin
        trial = {rem_q, dvd_q[2*N-1]};
        ge    = (trial >= {1'b0, dsr_q});
        diff  = trial[N-1:0] - dsr_q;
    end

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    dsr_d = bus.b;
                    cnt_d = '0;
                    if (bus.b == '0) begin
                        dvd_d   = '1;
                        rem_d   = bus.a[N-1:0];
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        dvd_d   = bus.a;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                // The remainder fits in N bits whenever ge is false, and the
                // difference fits in N bits whenever ge is true.
                rem_d = ge ? diff : trial[N-1:0];
                dvd_d = {dvd_q[2*N-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dsr_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.q           = dvd_q;
    assign bus.r           = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule
